// File: rtl/mmio_seq_multiplier.sv
// mmio_seq_multiplier: shift-add multiplier peripheral on the picorv32 native memory bus.
// Latency: bus ack one cycle after request; product WIDTH+1 cycles after the START edge (WIDTH+2 signed).
// Backpressure: none; every selected request is acked for one cycle, never in the cycle after an ack.
// Ports: clk, reset (async, active-high); mem_valid/mem_addr/mem_wdata/mem_wstrb request;
//        sel (window decode, combinational); mem_ready/mem_rdata registered response; irq = DONE.
// Optional: define MUL_SIGNED_EN to add the R/W SIGNED mode bit (CTRL bit2).
module mmio_seq_multiplier #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0FFF_FFE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        sel,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_reg, b_reg, mcand, mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [63:0]        res;
    logic               signed_cfg, start_signed, op_signed, op_neg;

    logic               access, busy, done, ctrl_wr, start, clr_done;
    logic [2:0]         idx;
    logic [31:0]        a_ext, b_ext, a_merged, b_merged, rd_val;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step, prod_fix;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               unused_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

    assign sel      = (mem_addr[31:5] == BASE_ADDR[31:5]);
    // !mem_ready forces a dead cycle between acknowledges.
    assign access   = mem_valid && sel && !mem_ready;
    assign idx      = mem_addr[4:2];
    assign busy     = (state == ST_BUSY) || (state == ST_FIX);
    assign done     = (state == ST_DONE);
    assign irq      = done;
    assign ctrl_wr  = access && (idx == 3'd4) && mem_wstrb[0];
    // START wins over CLR_DONE because it is tested first in the FSM.
    assign start    = ctrl_wr && mem_wdata[0] && !busy;
    assign clr_done = ctrl_wr && mem_wdata[1] && done;

    always_comb begin
        a_ext = '0;
        a_ext[WIDTH-1:0] = a_reg;
        b_ext = '0;
        b_ext[WIDTH-1:0] = b_reg;
        a_merged = merge_bytes(a_ext, mem_wdata, mem_wstrb);
        b_merged = merge_bytes(b_ext, mem_wdata, mem_wstrb);
    end

    // Magnitudes are taken at START so the shift-add core is always unsigned.
    assign a_mag = (start_signed && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign b_mag = (start_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;

    // Add into the upper half with a carry bit, then shift the whole accumulator right.
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    assign acc_step = {sum, acc[WIDTH-1:1]};
    assign prod_fix = op_neg ? -acc : acc;

    always_comb begin
        rd_val = '0;
        case (idx)
            3'd0: rd_val = a_ext;
            3'd1: rd_val = b_ext;
            3'd2: rd_val = res[31:0];
            3'd3: rd_val = res[63:32];
            3'd4: rd_val = {29'd0, signed_cfg, done, busy};
            default: rd_val = '0;
        endcase
    end

`ifdef MUL_SIGNED_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            signed_cfg <= 1'b0;
        else if (ctrl_wr)
            signed_cfg <= mem_wdata[2];
    end
    // A write carrying START samples the SIGNED value written alongside it.
    assign start_signed = mem_wdata[2];
`else
    assign signed_cfg   = 1'b0;
    assign start_signed = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= access;
            mem_rdata <= (access && mem_wstrb == 4'd0) ? rd_val : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            res       <= '0;
            op_signed <= 1'b0;
            op_neg    <= 1'b0;
        end else begin
            // Operand writes are always accepted; the working copies isolate a running product.
            if (access && mem_wstrb != 4'd0) begin
                if (idx == 3'd0) a_reg <= a_merged[WIDTH-1:0];
                if (idx == 3'd1) b_reg <= b_merged[WIDTH-1:0];
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mcand     <= a_mag;
                        mplier    <= b_mag;
                        acc       <= '0;
                        cnt       <= CW'(WIDTH);
                        op_signed <= start_signed;
                        op_neg    <= start_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                        state     <= ST_BUSY;
                    end else if (clr_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        acc    <= acc_step;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - CW'(1);
                    end else if (op_signed) begin
                        state <= ST_FIX;
                    end else begin
                        res   <= 64'(acc);
                        state <= ST_DONE;
                    end
                end
                ST_FIX: begin
                    res   <= 64'($signed(prod_fix));
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign unused_bits = ^{mem_addr[1:0], a_merged, b_merged};

endmodule

// File: tb/tb_mmio_seq_multiplier.sv
// tb_mmio_seq_multiplier: directed checks of a WIDTH=32 and a WIDTH=8 instance sharing one bus.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_mmio_seq_multiplier;
    localparam logic [31:0] B32 = 32'h0FFF_FFE0;
    localparam logic [31:0] B8  = 32'h0FFF_FFC0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        sel32, sel8, ready32, ready8, irq32, irq8;
    logic [31:0] rdata32, rdata8;
    logic        ready;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int s = 0;

    mmio_seq_multiplier #(.WIDTH(32), .BASE_ADDR(B32)) dut32 (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .sel(sel32),
        .mem_ready(ready32), .mem_rdata(rdata32), .irq(irq32)
    );

    mmio_seq_multiplier #(.WIDTH(8), .BASE_ADDR(B8)) dut8 (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .sel(sel8),
        .mem_ready(ready8), .mem_rdata(rdata8), .irq(irq8)
    );

    assign ready = ready32 | ready8;
    assign rdata = sel32 ? rdata32 : (sel8 ? rdata8 : 32'h0);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus access; holds valid an extra cycle to confirm the ack is a single pulse.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rd);
        int n = 0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready && n < 8);
        check("bus_ack", ready, 1);
        ack_cyc = cyc;
        rd = rdata;
        @(posedge clk); #1;
        check("ack_pulse", ready, 0);
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] r;
        bus(addr, wdata, strb, r);
    endtask

    task automatic rd_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        bus(addr, 32'h0, 4'd0, r);
        check(tag, r, exp);
    endtask

    // Cycles from the START ack edge to the first edge showing irq=1.
    task automatic wait_done(input bit use8, input int start_cyc, input int exp_lat, input string tag);
        int n = 0;
        while (((use8 ? irq8 : irq32) !== 1'b1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, cyc - start_cyc, exp_lat);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq32", irq32, 0);
        check("rst_irq8", irq8, 0);
        check("rst_ready", ready, 0);
        check("rst_rdata", rdata32, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) rd_check(B32 + 32'(4 * i), 32'h0, "rst_read");

        // WIDTH=32 all-ones square
        wr(B32 + 0, 32'hFFFF_FFFF, 4'hF);
        wr(B32 + 4, 32'hFFFF_FFFF, 4'hF);
        wr(B32 + 16, 32'h1, 4'h1);
        s = ack_cyc;
        rd_check(B32 + 16, 32'h1, "busy_stat");
        wait_done(1'b0, s, 33, "lat32");
        check("irq32_set", irq32, 1);
        rd_check(B32 + 16, 32'h2, "done_stat");
        rd_check(B32 + 8, 32'h0000_0001, "ff_res_lo");
        rd_check(B32 + 12, 32'hFFFF_FFFE, "ff_res_hi");

        // WIDTH=8 truncation and product
        wr(B8 + 0, 32'h1234_56C8, 4'hF);
        wr(B8 + 4, 32'h0000_000F, 4'hF);
        rd_check(B8 + 0, 32'h0000_00C8, "w8_a_trunc");
        wr(B8 + 16, 32'h1, 4'h1);
        s = ack_cyc;
        wait_done(1'b1, s, 9, "lat8");
        rd_check(B8 + 8, 32'h0000_0BB8, "w8_res_lo");
        rd_check(B8 + 12, 32'h0, "w8_res_hi");

        // CLR_DONE, unmapped offset, CTRL write without byte 0
        wr(B32 + 16, 32'h2, 4'h1);
        rd_check(B32 + 16, 32'h0, "clr_stat");
        check("clr_irq", irq32, 0);
        rd_check(B32 + 8, 32'h0000_0001, "clr_keep_lo");
        rd_check(B32 + 12, 32'hFFFF_FFFE, "clr_keep_hi");
        wr(B32 + 20, 32'hFFFF_FFFF, 4'hF);
        rd_check(B32 + 20, 32'h0, "unmapped");
        wr(B32 + 16, 32'h0000_0101, 4'b0010);
        rd_check(B32 + 16, 32'h0, "ctrl_no_b0");

        // Byte strobes, START and B write while busy
        wr(B32 + 0, 32'h0, 4'hF);
        wr(B32 + 0, 32'h0000_AB00, 4'b0010);
        rd_check(B32 + 0, 32'h0000_AB00, "byte_wr_a");
        wr(B32 + 4, 32'h3, 4'hF);
        wr(B32 + 16, 32'h1, 4'h1);
        s = ack_cyc;
        wr(B32 + 16, 32'h1, 4'h1);
        wr(B32 + 4, 32'h5, 4'hF);
        rd_check(B32 + 8, 32'h0000_0001, "res_hold");
        wait_done(1'b0, s, 33, "lat_ign_start");
        rd_check(B32 + 8, 32'h0002_0100, "mul3_lo");
        rd_check(B32 + 12, 32'h0, "mul3_hi");
        rd_check(B32 + 4, 32'h5, "b_busy_wr");
        wr(B32 + 16, 32'h1, 4'h1);
        s = ack_cyc;
        wait_done(1'b0, s, 33, "lat_restart");
        rd_check(B32 + 8, 32'h0003_5700, "mul5_lo");

`ifdef MUL_SIGNED_EN
        // Signed: -3 * 7
        wr(B32 + 0, 32'hFFFF_FFFD, 4'hF);
        wr(B32 + 4, 32'h7, 4'hF);
        wr(B32 + 16, 32'h4, 4'h1);
        wr(B32 + 16, 32'h5, 4'h1);
        s = ack_cyc;
        wait_done(1'b0, s, 34, "lat_signed");
        rd_check(B32 + 8, 32'hFFFF_FFEB, "sgn_lo");
        rd_check(B32 + 12, 32'hFFFF_FFFF, "sgn_hi");
        rd_check(B32 + 16, 32'h6, "sgn_stat");
`endif

        // Asynchronous reset in mid-operation
        wr(B32 + 16, 32'h1, 4'h1);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_irq8", irq8, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_irq8", irq8, 0);
        check("async_ready", ready, 0);
        check("async_rdata", rdata32, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) rd_check(B32 + 32'(4 * i), 32'h0, "mid_rst_read");
        rd_check(B8 + 0, 32'h0, "mid_rst_a8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
